// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, constants and rotating priority search for rr_arbiter_8
package arb_pkg;

    localparam int unsigned N_REQ        = 8;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned HOLD_W       = 8;
    localparam int unsigned DEF_MAX_HOLD = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Rotating priority search: first set bit of (req & ~mask), scanning
    // upward from ptr and wrapping. Returns a one-hot vector, zero if none.
    function automatic logic [N_REQ-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr,
        input logic [N_REQ-1:0] mask
    );
        logic [N_REQ-1:0] cand;
        logic [N_REQ-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        cand  = req & ~mask;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && cand[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/onehot_enc_8to3.sv
// rtl/onehot_enc_8to3.sv - OR-based one-hot to binary encoder, 8 to 3
module onehot_enc_8to3
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    // Each index bit is the OR of the inputs whose position has that bit set;
    // a zero input yields index 0.
    always_comb begin
        idx    = '0;
        idx[0] = onehot[1] | onehot[3] | onehot[5] | onehot[7];
        idx[1] = onehot[2] | onehot[3] | onehot[6] | onehot[7];
        idx[2] = onehot[4] | onehot[5] | onehot[6] | onehot[7];
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - eight-way round-robin arbiter with done/drop/hold-timeout release
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic              timeout_q, timeout_d;
    logic              load_ptr;

    logic [N_REQ-1:0]  pick_mask;
    logic [N_REQ-1:0]  pick;
    logic              rel_done, rel_drop, rel_hold, release_now;

    // Release reasons for the current owner; all are inert while idle
    // because gnt_q is zero and the state check gates them.
    always_comb begin
        rel_done    = 1'b0;
        rel_drop    = 1'b0;
        rel_hold    = 1'b0;
        if (state_q == GRANT) begin
            rel_done = done;
            rel_drop = ~|(req & gnt_q);
            rel_hold = (hold_cnt == HOLD_LAST);
        end
        release_now = rel_done | rel_drop | rel_hold;
    end

    // The current owner is masked out of the search so a still-asserting
    // owner cannot re-win on its own release.
    always_comb begin
        pick_mask = (state_q == GRANT) ? gnt_q : '0;
        pick      = rr_pick(req, ptr, pick_mask);
    end

    // Next-state and next-grant decisions.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        hold_d    = hold_cnt;
        timeout_d = 1'b0;
        load_ptr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = pick;
                    hold_d   = '0;
                    load_ptr = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    timeout_d = rel_hold & ~rel_done & ~rel_drop;
                    hold_d    = '0;
                    if (|pick) begin
                        gnt_d    = pick;
                        load_ptr = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                hold_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    onehot_enc_8to3 u_enc (
        .onehot (gnt_d),
        .idx    (gnt_idx_d)
    );

    // Register grant, index, pointer, hold counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            hold_cnt  <= hold_d;
            timeout_q <= timeout_d;
            if (load_ptr) begin
                ptr <= gnt_idx_d + IDX_W'(1);
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int errors;
    int checks;
    int to_pulses;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        if (timeout) to_pulses++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input logic [7:0] g, input logic [2:0] idx);
        check({tag, "_gnt"}, 32'(gnt), 32'(g));
        check({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, "_valid"}, 32'(gnt_valid), 32'(g != 8'h00));
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        to_pulses = 0;
        rst       = 1'b1;
        req       = 8'h00;
        done      = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        expect_grant("reset", 8'h00, 3'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check("reset_ptr", 32'(dut.ptr), 32'd0);
        check("reset_hold", 32'(dut.hold_cnt), 32'd0);

        // done while idle is ignored
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("idle_done", 8'h00, 3'd0);

        // Single request
        req = 8'h20;
        tick();
        expect_grant("single", 8'h20, 3'd5);
        check("single_ptr", 32'(dut.ptr), 32'd6);
        req = 8'h00;
        tick();
        expect_grant("single_rel", 8'h00, 3'd0);

        // Round-robin fairness, done every third grant cycle
        do_reset();
        req = 8'hFF;
        tick();
        expect_grant("rr_first", 8'h01, 3'd0);
        for (int g = 1; g <= 8; g++) begin
            tick();
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            expect_grant($sformatf("rr_%0d", g), 8'h01 << (g % 8), 3'(g % 8));
            check($sformatf("rr_to_%0d", g), 32'(timeout), 32'd0);
        end

        // Back-to-back handoff 2 -> 3
        do_reset();
        req = 8'h04;
        tick();
        expect_grant("b2b_own", 8'h04, 3'd2);
        req  = 8'h0C;
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("b2b_next", 8'h08, 3'd3);

        // Owner done with no other requester -> idle
        do_reset();
        req = 8'h04;
        tick();
        expect_grant("solo_own", 8'h04, 3'd2);
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("solo_idle", 8'h00, 3'd0);
        check("solo_state", 32'(dut.state_q), 32'd0);

        // Hold timeout with MAX_HOLD=4
        do_reset();
        to_pulses = 0;
        req = 8'h03;
        tick();
        expect_grant("to_c1", 8'h01, 3'd0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check($sformatf("to_c%0d_gnt", c), 32'(gnt), 32'h01);
            check($sformatf("to_c%0d_to", c), 32'(timeout), 32'd0);
        end
        tick();
        expect_grant("to_next", 8'h02, 3'd1);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_ptr", 32'(dut.ptr), 32'd2);
        tick();
        check("to_after", 32'(timeout), 32'd0);
        check("to_count", 32'(to_pulses), 32'd1);

        // Request drop by owner 7 hands over to 0 with no timeout
        do_reset();
        req = 8'h80;
        tick();
        expect_grant("drop_own", 8'h80, 3'd7);
        req = 8'h01;
        tick();
        expect_grant("drop_next", 8'h01, 3'd0);
        check("drop_to", 32'(timeout), 32'd0);

        // Reset mid-grant
        do_reset();
        req = 8'h10;
        tick();
        expect_grant("mid_own", 8'h10, 3'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_grant("mid_rst", 8'h00, 3'd0);
        check("mid_rst_to", 32'(timeout), 32'd0);
        check("mid_rst_ptr", 32'(dut.ptr), 32'd0);
        req = 8'h11;
        tick();
        expect_grant("mid_after", 8'h01, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares a single downstream resource among eight requesters. It produces a registered one-hot grant and the matching 3-bit grant index. The owner holds the grant until it signals completion, drops its request, or exceeds a hold timeout. The arbiter sits in front of the shared datapath and drives its select lines directly from `gnt_idx`.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant (legal range 2..255).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `req` input 8: request lines; `req[i]`=1 means requester i wants the resource.
- `done` input 1: single-cycle pulse from the current owner marking the end of its transaction. Ignored when `gnt_valid`=0.
- `gnt` output 8: registered one-hot grant; all zeros when idle.
- `gnt_idx` output 3: binary index of the set bit of `gnt`; 0 when idle.
- `gnt_valid` output 1: 1 when a grant is active (OR of `gnt`).
- `timeout` output 1: single-cycle pulse in the cycle a grant is forcibly revoked by the hold limit.

## Operation
- State machine with two states, IDLE and GRANT. Reset enters IDLE.
- Reset values:
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0.
  - Rotation pointer `ptr`=0.
  - Hold counter `hold_cnt`=0.
- Selection: search `req` starting at index `ptr` and ascending with wrap (ptr, ptr+1, …, 7, 0, …, ptr-1). The first set bit wins. The search is combinational.
- IDLE:
  - If `req`≠0, load the winner k into `gnt`, set `ptr`←(k+1) mod 8, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, owner k:
  - `hold_cnt` increments each cycle and saturates at `MAX_HOLD`.
  - A release occurs when any of these is true: `done`=1, `req[k]`=0, or `hold_cnt`=`MAX_HOLD`-1.
  - On release, re-run selection with `req[k]` masked off:
    - If another request exists, grant it directly (back-to-back, no idle cycle), update `ptr`, and clear `hold_cnt`.
    - Otherwise clear `gnt` and go to IDLE.
  - `timeout` pulses only when the hold limit causes the release. It does not pulse if `done` or a `req[k]` drop occurs in the same cycle.
- Masking `k` during release guarantees that a requester which is still asserting cannot immediately re-win. It may win again only after at least one other grant, or after an idle cycle.
- `gnt_idx` comes from `gnt` through the encoder sub-module and is registered alongside `gnt`. It is never decoded from `ptr`.
- Reset mid-grant: `gnt` drops to 0 on the next edge and the in-flight transaction is abandoned. No `timeout` pulse is generated.

## Timing
- Request to grant latency: `req` sampled at edge N in IDLE gives `gnt`/`gnt_idx`/`gnt_valid` valid after edge N+1.
- Release to next grant: a release condition seen at edge M gives a new grant, or idle, after edge M+1. Bus turnaround is therefore zero cycles.
- Maximum grant duration is `MAX_HOLD` cycles.
- Worst-case wait for a continuously asserting requester is 7×`MAX_HOLD` cycles plus 1.
- Simultaneous `done` and new `req` edges from other requesters are both honoured in the same cycle.
- `gnt` is always either one-hot or zero. This holds in every cycle, including directly after reset.

## Structure
- Shared package `arb_pkg`:
  - `N_REQ`=8 and `IDX_W`=3.
  - State enum `arb_state_t` {IDLE, GRANT}.
  - Default `MAX_HOLD`.
- Sub-module `onehot_enc_8to3`: combinational OR-based one-hot to binary encoder, 8 inputs to 3 outputs. It is instantiated once, between the next-grant logic and the `gnt_idx` register.
- The rotating priority search is a function in `arb_pkg`, taking `req`, `ptr` and a mask and returning a one-hot result.

## Test plan
- Reset then single request: `req`=8'h20 → one cycle later `gnt`=8'h20, `gnt_idx`=5, `gnt_valid`=1, and `ptr` becomes 6.
- Round-robin fairness: `req`=8'hFF held, `done` pulsed every 3 cycles → grants go 0,1,2,…,7,0 in order, and each `gnt_idx` matches.
- Back-to-back handoff: owner 2 holding, `req`=8'h0C, `done` at cycle M → `gnt`=8'h08 at M+1 with no idle cycle. If instead `req`=8'h04 only, `gnt`=0 at M+1 and the arbiter returns to IDLE.
- Hold timeout, `MAX_HOLD`=4: `req`=8'h03 held and no `done` → requester 0 owns the grant for exactly 4 cycles, `timeout` pulses once, then requester 1 is granted.
- Request drop: owner 7 deasserts `req[7]` while `req`=8'h01 → `gnt`=8'h01 next cycle and `timeout`=0.
- Reset mid-grant: `rst`=1 while `gnt`=8'h10 → after the edge all outputs are 0 and `ptr`=0. With `req`=8'h11 after reset, requester 0 wins first.
